// File: rtl/posit_defines_pkg.sv
// Shared posit definitions: unpacked-value struct, special-constant helper, log2 helper.
// Contents: P_* default configuration, posit_unpacked_t, posit_const(), log2_ceil().
// posit_unpacked_t is sized by the P_* defaults; blocks using it must keep their widths equal to them.
package posit_defines;

    localparam int P_N       = 16;
    localparam int P_ES      = 1;
    localparam int P_FRAC_W  = 24;
    localparam int P_SCALE_W = 8;

    typedef enum logic [1:0] {
        PC_MAXPOS,
        PC_MINPOS,
        PC_NAR
    } posit_const_e;

    typedef struct packed {
        logic                        sign;
        logic signed [P_SCALE_W-1:0] scale;
        logic [P_FRAC_W-1:0]         frac;
        logic                        sticky;
        logic                        zero;
        logic                        nar;
    } posit_unpacked_t;

    // Special encodings for an n-bit posit, returned LSB-aligned in 64 bits.
    function automatic logic [63:0] posit_const(input posit_const_e kind, input int n);
        logic [63:0] top;
        top = 64'd1 << (n - 1);
        case (kind)
            PC_MAXPOS: return top - 64'd1;
            PC_MINPOS: return 64'd1;
            default:   return top;
        endcase
    endfunction

    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/posit_encoder_pipe_round.sv
// Combinational RNE rounding, saturation clamp and two's-complement negate of a posit magnitude.
// Ports: sign/zero/nar/sat_hi/sat_lo flags, mag (C_N-1 bits), guard, sticky -> posit (C_N bits).
// Purely combinational; no handshake.
module posit_round_rne
    import posit_defines::*;
#(
    parameter int C_N = 16
) (
    input  logic           sign,
    input  logic           zero,
    input  logic           nar,
    input  logic           sat_hi,
    input  logic           sat_lo,
    input  logic [C_N-2:0] mag,
    input  logic           guard,
    input  logic           sticky,
    output logic [C_N-1:0] posit
);

    localparam logic [63:0]    MAXPOS_W = posit_const(PC_MAXPOS, C_N);
    localparam logic [63:0]    MINPOS_W = posit_const(PC_MINPOS, C_N);
    localparam logic [63:0]    NAR_W    = posit_const(PC_NAR, C_N);
    localparam logic [C_N-1:0] MAXPOS   = MAXPOS_W[C_N-1:0];
    localparam logic [C_N-1:0] MINPOS   = MINPOS_W[C_N-1:0];
    localparam logic [C_N-1:0] NAR      = NAR_W[C_N-1:0];

    logic           round_up;
    logic [C_N-1:0] mag_r;
    logic [C_N-1:0] mag_c;
    logic [C_N-1:0] signed_val;

    always_comb begin
        round_up = guard & (sticky | mag[0]);
        // One spare MSB catches a rounding carry that would reach the sign position.
        mag_r = {1'b0, mag} + {{(C_N-1){1'b0}}, round_up};
        if (sat_hi || mag_r[C_N-1]) begin
            mag_c = MAXPOS;
        end else if (sat_lo || (mag_r == '0)) begin
            mag_c = MINPOS;
        end else begin
            mag_c = mag_r;
        end
        signed_val = sign ? (~mag_c + {{(C_N-1){1'b0}}, 1'b1}) : mag_c;
        if (nar) begin
            posit = NAR;
        end else if (zero) begin
            posit = '0;
        end else begin
            posit = signed_val;
        end
    end

endmodule

// File: rtl/posit_encoder_pipe.sv
// Pipelined posit packer: unpacked (sign, scale, frac, sticky, zero, nar) -> C_N-bit posit, RNE.
// Ports: clk/rst (sync, active-high), in_* valid/ready input beat, out_* valid/ready posit output.
// Latency 3 cycles, 1 beat/cycle; global enable en = ~out_valid | out_ready stalls all stages.
module posit_encoder_pipe
    import posit_defines::*;
#(
    parameter int C_N       = P_N,
    parameter int C_ES      = P_ES,
    parameter int C_FRAC_W  = P_FRAC_W,
    parameter int C_SCALE_W = P_SCALE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [C_SCALE_W-1:0] in_scale,
    input  logic [C_FRAC_W-1:0]  in_frac,
    input  logic                 in_sticky,
    input  logic                 in_zero,
    input  logic                 in_nar,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [C_N-1:0]       out_posit
);

    localparam int E_W  = (C_ES > 0) ? C_ES : 1;
    localparam int SH_W = log2_ceil(C_N);
    localparam int BW   = 2 * C_N + C_FRAC_W;
    localparam int PAD  = BW - 2 - E_W - C_FRAC_W;
    localparam logic signed [C_SCALE_W-1:0] K_HI = C_SCALE_W'(C_N - 2);
    localparam logic signed [C_SCALE_W-1:0] K_LO = C_SCALE_W'(-(C_N - 1));

    typedef struct packed {
        logic           sign;
        logic           zero;
        logic           nar;
        logic           sat_hi;
        logic           sat_lo;
        logic [C_N-2:0] mag;
        logic           guard;
        logic           sticky;
    } s2_t;

    logic en;

    logic                       s1_vld_q, s1_vld_d;
    posit_unpacked_t            s1_pkt_q, s1_pkt_d;
    logic                       s1_sat_hi_q, s1_sat_hi_d;
    logic                       s1_sat_lo_q, s1_sat_lo_d;
    logic [SH_W-1:0]            s1_sh_q, s1_sh_d;
    logic                       s2_vld_q, s2_vld_d;
    s2_t                        s2_q, s2_d;
    logic                       out_valid_q, out_valid_d;
    logic [C_N-1:0]             out_posit_q, out_posit_d;

    logic signed [C_SCALE_W-1:0] k;
    logic [C_SCALE_W-1:0]        sh_full;
    logic [E_W+C_FRAC_W-1:0]     ef;
    logic signed [BW-1:0]        seed;
    logic signed [BW-1:0]        shifted;
    logic [C_N-1:0]              posit_rnd;
    logic                        unused_ok;

    assign en        = ~out_valid_q | out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_posit = out_posit_q;
    assign unused_ok = ^{sh_full[C_SCALE_W-1:SH_W], s1_pkt_q.scale[C_SCALE_W-2:E_W]};

    // S1: split scale into regime k and exponent e; both regime codes reduce to a
    // shift of (rl - 2) applied to a 2-bit lead, which is k for k >= 0 and ~k for k < 0.
    always_comb begin
        k       = $signed(in_scale) >>> C_ES;
        sh_full = k[C_SCALE_W-1] ? ~k : k;

        s1_vld_d    = s1_vld_q;
        s1_pkt_d    = s1_pkt_q;
        s1_sat_hi_d = s1_sat_hi_q;
        s1_sat_lo_d = s1_sat_lo_q;
        s1_sh_d     = s1_sh_q;
        if (en) begin
            s1_vld_d        = in_valid;
            s1_pkt_d.sign   = in_sign;
            s1_pkt_d.scale  = in_scale;
            s1_pkt_d.frac   = in_frac;
            s1_pkt_d.sticky = in_sticky;
            s1_pkt_d.zero   = in_zero;
            s1_pkt_d.nar    = in_nar;
            s1_sat_hi_d     = (k >= K_HI);
            s1_sat_lo_d     = (k <= K_LO);
            // Saturated values are clamped later; keep the shifter in range.
            s1_sh_d         = (s1_sat_hi_d || s1_sat_lo_d) ? '0 : sh_full[SH_W-1:0];
        end
    end

    // S2: lead 10 sign-extends into (k+1) ones then a zero; lead 01 gives (-k) zeros then a one.
    always_comb begin
        // With C_ES = 0 the unused e bit is shifted out of the top.
        ef      = {s1_pkt_q.scale[E_W-1:0], s1_pkt_q.frac} << (E_W - C_ES);
        seed    = {(s1_pkt_q.scale[C_SCALE_W-1] ? 2'b01 : 2'b10), ef, {PAD{1'b0}}};
        shifted = seed >>> s1_sh_q;

        s2_vld_d = s2_vld_q;
        s2_d     = s2_q;
        if (en) begin
            s2_vld_d      = s1_vld_q;
            s2_d.sign     = s1_pkt_q.sign;
            s2_d.zero     = s1_pkt_q.zero;
            s2_d.nar      = s1_pkt_q.nar;
            s2_d.sat_hi   = s1_sat_hi_q;
            s2_d.sat_lo   = s1_sat_lo_q;
            s2_d.mag      = shifted[BW-1 -: C_N-1];
            s2_d.guard    = shifted[BW-C_N];
            s2_d.sticky   = (|shifted[BW-C_N-1:0]) | s1_pkt_q.sticky;
        end
    end

    posit_round_rne #(
        .C_N (C_N)
    ) u_round (
        .sign   (s2_q.sign),
        .zero   (s2_q.zero),
        .nar    (s2_q.nar),
        .sat_hi (s2_q.sat_hi),
        .sat_lo (s2_q.sat_lo),
        .mag    (s2_q.mag),
        .guard  (s2_q.guard),
        .sticky (s2_q.sticky),
        .posit  (posit_rnd)
    );

    // S3: output register; bubbles leave the last posit on the bus with out_valid low.
    always_comb begin
        out_valid_d = out_valid_q;
        out_posit_d = out_posit_q;
        if (en) begin
            out_valid_d = s2_vld_q;
            if (s2_vld_q) begin
                out_posit_d = posit_rnd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_pkt_q    <= '0;
            s1_sat_hi_q <= 1'b0;
            s1_sat_lo_q <= 1'b0;
            s1_sh_q     <= '0;
            s2_vld_q    <= 1'b0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_posit_q <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_pkt_q    <= s1_pkt_d;
            s1_sat_hi_q <= s1_sat_hi_d;
            s1_sat_lo_q <= s1_sat_lo_d;
            s1_sh_q     <= s1_sh_d;
            s2_vld_q    <= s2_vld_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            out_posit_q <= out_posit_d;
        end
    end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Self-checking bench for posit_encoder_pipe (C_N=16, C_ES=1, C_FRAC_W=24, C_SCALE_W=8).
// Directed beats push expected posits to a scoreboard; a negedge monitor pops on each output handshake.
// Covers reset, encoding/rounding/saturation/specials, backpressure stall and mid-stream reset.
module tb_posit_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_scale;
    logic [23:0] in_frac;
    logic        in_sticky;
    logic        in_zero;
    logic        in_nar;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_posit;

    logic [15:0] sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_out    = 0;

    always #5 clk = ~clk;

    posit_encoder_pipe #(
        .C_N       (16),
        .C_ES      (1),
        .C_FRAC_W  (24),
        .C_SCALE_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .in_sticky (in_sticky),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: an output beat transfers at the next posedge when valid & ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_output", 32'(out_posit), 32'hFFFF_FFFF);
            end else begin
                check($sformatf("out_posit_beat%0d", n_out), 32'(out_posit), 32'(sb.pop_front()));
            end
        end
    end

    task automatic send(input logic s, input int sc, input logic [23:0] f, input logic st,
                        input logic z, input logic n, input logic [15:0] exp);
        int c;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sign   = s;
        in_scale  = sc[7:0];
        in_frac   = f;
        in_sticky = st;
        in_zero   = z;
        in_nar    = n;
        c = 0;
        while (!in_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            sb.push_back(exp);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_scale = '0; in_frac = '0; in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_posit", 32'(out_posit), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Basic values
        send(1'b0,    0, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h4000);
        send(1'b1,    0, 24'h000000, 1'b0, 1'b0, 1'b0, 16'hC000);
        send(1'b0,    1, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h5000);
        send(1'b0,   -1, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h3000);
        // Rounding
        send(1'b0,    0, 24'h000800, 1'b0, 1'b0, 1'b0, 16'h4000);
        send(1'b0,    0, 24'h001800, 1'b0, 1'b0, 1'b0, 16'h4002);
        send(1'b0,    0, 24'h000800, 1'b1, 1'b0, 1'b0, 16'h4001);
        send(1'b1,    0, 24'h001800, 1'b0, 1'b0, 1'b0, 16'hBFFE);
        // Saturation and regime extremes
        send(1'b0,  100, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h7FFF);
        send(1'b1,  100, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h8001);
        send(1'b0, -100, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h0001);
        send(1'b1, -100, 24'h000000, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        send(1'b0,   27, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 16'h7FFF);
        send(1'b0,   26, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 16'h7FFE);
        send(1'b0,  -27, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h0002);
        // Specials
        send(1'b1,    5, 24'h123456, 1'b1, 1'b0, 1'b1, 16'h8000);
        send(1'b1,    3, 24'h00ABCD, 1'b0, 1'b1, 1'b0, 16'h0000);
        send(1'b0,    0, 24'h000000, 1'b0, 1'b1, 1'b1, 16'h8000);
        idle();
        drain();

        // Backpressure: hold out_ready low right after the first output transfers.
        out_ready = 1'b1;
        fork
            begin
                send(1'b0,  0, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h4000);
                send(1'b1,  0, 24'h000000, 1'b0, 1'b0, 1'b0, 16'hC000);
                send(1'b0,  1, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h5000);
                send(1'b0, -1, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h3000);
                send(1'b0,  0, 24'h001800, 1'b0, 1'b0, 1'b0, 16'h4002);
                send(1'b0,  0, 24'h000800, 1'b1, 1'b0, 1'b0, 16'h4001);
                idle();
            end
            begin
                c = 0;
                @(negedge clk);
                while (!out_valid && c < 100) begin
                    @(negedge clk);
                    c++;
                end
                check("bp_first_output", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_stall_out_valid", 32'(out_valid), 32'd1);
                    check("bp_stall_in_ready", 32'(in_ready), 32'd0);
                    check("bp_stall_out_posit", 32'(out_posit), 32'(sb[0]));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Mid-stream reset with three beats in flight.
        send(1'b0,  0, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h4000);
        send(1'b0,  1, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h5000);
        send(1'b0, -1, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h3000);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_posit", 32'(out_posit), 32'd0);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        send(1'b0, 1, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h5000);
        idle();
        drain();

        check("total_output_beats", 32'(n_out), 32'd25);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/posit_encoder_pipe.md
Name: posit_encoder_pipe

Overview:
Pipelined posit packer. It is the inverse of the leading-one/regime decode path: it takes an unpacked value (sign, scale, normalized fraction, sticky, special flags) and produces an N-bit posit. Rounding is round-to-nearest-even with posit saturation semantics. It sits at the tail of the posit arithmetic units (adder, multiplier, quire readout) and uses a valid/ready stream on both sides.

Parameters:
- C_N, 16, posit width in bits (≥ 8).
- C_ES, 1, exponent field width (0..3).
- C_FRAC_W, 24, input fraction width. Hidden bit excluded; MSB-aligned, so frac[C_FRAC_W-1] has weight 2^-1.
- C_SCALE_W, 8, signed scale width. Must cover ±(C_N-1)·2^C_ES plus margin.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted when in_valid & in_ready.
- in_sign, in, 1, sign of value.
- in_scale, in, C_SCALE_W, signed power-of-two exponent; value = (1.frac)·2^scale.
- in_frac, in, C_FRAC_W, fraction bits after the hidden one.
- in_sticky, in, 1, OR of discarded bits below in_frac.
- in_zero, in, 1, value is exactly zero.
- in_nar, in, 1, value is NaR; has priority over in_zero.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts the output.
- out_posit, out, C_N, encoded posit (two's-complement form for negatives).

Behaviour:
- Reset: all stage valids are 0, out_valid = 0, out_posit = 0. A reset mid-stream drops all in-flight beats; in_ready is 1 in the cycle after reset deasserts.
- Latency: 3 cycles from the accepted input to out_valid. Throughput is 1 beat/cycle with no stall.
- Stall: en = ~out_valid | out_ready, and in_ready = en.
  - When en = 0, every stage holds; out_posit and out_valid stay stable.
  - Bubbles do not collapse; this is a simple global-enable pipeline.
- S1 (decompose):
  - k = in_scale >>> C_ES (arithmetic shift); e = in_scale[C_ES-1:0].
  - Regime length: rl = k+2 if k ≥ 0, else -k+1.
  - sat_hi = (k ≥ C_N-2); sat_lo = (k ≤ -(C_N-1)).
  - Register sign, zero, nar, frac, sticky.
- S2 (assemble):
  - Build the magnitude string {regime, e, frac}. Regime is (k+1) ones then a zero for k ≥ 0, or (-k) zeros then a one for k < 0.
  - Place it right-justified after the sign into a (2·C_N + C_FRAC_W)-bit buffer using a right shift by rl.
  - Keep the top C_N-1 bits as mag. guard = the next bit. sticky = OR(all remaining bits, in_sticky).
- S3 (round/finish):
  - round_up = guard & (sticky | mag[0]); mag_r = mag + round_up.
  - Clamp:
    - If sat_hi or mag_r overflows into the sign bit, mag_r = maxpos (0111…1).
    - If sat_lo, or mag_r = 0 with a nonzero input, mag_r = minpos (000…01).
  - A nonzero value never encodes to 0 or NaR.
  - out_posit = sign ? -{0,mag_r} : {0,mag_r}.
  - NaR → {1,0…0}, ignoring all other fields. Otherwise zero → all 0.
- Carry from fraction rounding into the exponent/regime fields is legal and is not special-cased.
- out_ready may be 1 while out_valid is 0; that is a no-op.

Decomposition:
- posit_defines package:
  - posit_unpacked_t struct (sign, scale, frac, sticky, zero, nar).
  - Function returning maxpos/minpos/NaR constants per C_N.
  - Existing log2 helper.
- One sub-module, posit_round_rne: S3 combinational rounding, clamp, and negate. Reused by the quire path.

Test Plan (C_N=16, C_ES=1, C_FRAC_W=24):
- Basic values:
  - scale=0, frac=0, sign=0 → 0x4000.
  - Same with sign=1 → 0xC000.
  - scale=1 → 0x5000.
  - scale=-1 → 0x3000.
- Rounding:
  - scale=0, frac=0x000800, sticky=0 → 0x4000 (tie, round to even).
  - frac=0x001800 → 0x4002.
  - frac=0x000800, sticky=1 → 0x4001.
- Saturation:
  - scale=+100 → 0x7FFF; with sign=1 → 0x8001.
  - scale=-100 → 0x0001.
  - scale=27, frac=0xFFFFFF → 0x7FFF; never 0x8000.
- Specials:
  - in_nar=1 with any fields → 0x8000.
  - in_zero=1 → 0x0000.
  - in_nar=1 and in_zero=1 together → 0x8000.
- Backpressure: stream 6 beats with out_ready held low after the first output.
  - Required: out_posit stable and in_ready=0 while stalled.
  - After release: all 6 outputs emerge in order, no loss or duplication.
- Reset mid-stream: assert rst with 3 beats in flight.
  - Required next cycle: out_valid=0, out_posit=0; no stale beat appears afterward.
